bounce_shifter: RTL

//   Downstream consumer of the timer's one-cycle 'out' pulse. Holds a one-hot
//   LED pattern and moves it one position per timer tick, bouncing between the
//   two ends. Also counts the reflections. Shift speed is set only by the

---
 rtl/bounce_shifter.sv | 98 +++++++++
 1 files changed

// File: rtl/bounce_shifter.sv
// One-hot LED pattern that moves one position per timer tick, bouncing between ends.
// Optional end dwell enabled by defining BOUNCE_SHIFTER_DWELL_EN.
module bounce_shifter #(
  parameter int WIDTH = 8,
  parameter int BCW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             dir_flip,
  output logic [WIDTH-1:0] leds,
  output logic             dir,
  output logic             at_edge,
  output logic [BCW-1:0]   bounces
);

`ifdef BOUNCE_SHIFTER_DWELL_EN
  typedef enum logic [1:0] {MOVE_L, MOVE_R, DWELL} state_t;
`else
  typedef enum logic [1:0] {MOVE_L, MOVE_R} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             pend_q, pend_d;
  logic [BCW-1:0]   bnc_q, bnc_d;
  logic             in_dwell;
  logic             eff;
  logic [WIDTH-1:0] nxt;
  logic             hit_end;

`ifdef BOUNCE_SHIFTER_DWELL_EN
  assign in_dwell = (state_q == DWELL);
`else
  assign in_dwell = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    dir_d   = dir_q;
    bnc_d   = bnc_q;
    pend_d  = pend_q ^ dir_flip;
    eff     = dir_q ^ pend_q;
    nxt     = leds_q;
    hit_end = 1'b0;
    if (tick && enable) begin
      // A flip arriving with the consuming tick is kept for the following tick.
      pend_d = dir_flip;
      if (in_dwell) begin
        state_d = dir_q ? MOVE_R : MOVE_L;
      end else begin
        if (leds_q[0])
          eff = 1'b0;
        else if (leds_q[WIDTH-1])
          eff = 1'b1;
        nxt     = eff ? (leds_q >> 1) : (leds_q << 1);
        leds_d  = nxt;
        dir_d   = eff;
        hit_end = nxt[0] | nxt[WIDTH-1];
        if (hit_end) begin
          dir_d = nxt[WIDTH-1];
          if (bnc_q != '1)
            bnc_d = bnc_q + 1'b1;
        end
        state_d = dir_d ? MOVE_R : MOVE_L;
`ifdef BOUNCE_SHIFTER_DWELL_EN
        if (hit_end)
          state_d = DWELL;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MOVE_L;
      leds_q  <= WIDTH'(1);
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      bnc_q   <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      bnc_q   <= bnc_d;
    end
  end

  assign leds    = leds_q;
  assign dir     = dir_q;
  assign bounces = bnc_q;
  assign at_edge = leds_q[0] | leds_q[WIDTH-1];

endmodule
